add2_pipe: RTL
==============

ADD2_PIPE -- requirements
Module: add2_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (signed, two's complement, WIDTH >= 2).
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries (DEPTH >= 1).
REQ-003 SHALL have parameter SATURATE, default 0, overflow mode: 0 wrap, 1 saturate.
REQ-004 SHALL use one clock and a synchronous active-high reset, as the ports below define.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  operand pair present.
REQ-008 in_ready  output  1  block accepts operand pair this cycle.
REQ-009 in_port_1  input  WIDTH  signed operand A.
REQ-010 in_port_2  input  WIDTH  signed operand B.
REQ-011 in_acc  input  1  add the running accumulator into this result.
REQ-012 out_valid  output  1  out_port holds a result.
REQ-013 out_ready  input  1  consumer takes the result this cycle.
REQ-014 out_port  output  WIDTH  signed result, head of buffer.
REQ-015 out_ovf  output  1  overflow flag of the head result.

Function
REQ-016 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer on a rising edge where out_valid && out_ready.
REQ-017 in_ready SHALL equal (count < DEPTH); there is no pass-through when full, even if a pop happens in the same cycle.
REQ-018 Raw sum SHALL be computed at WIDTH+2 bits, sign-extended: A + B + (in_acc ? acc : 0).
REQ-019 Overflow SHALL be flagged when the raw sum lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 SATURATE=0: result SHALL be the raw sum truncated to WIDTH bits; SATURATE=1: result SHALL clamp to the signed max or min.
REQ-021 Each input transfer SHALL push {result, ovf} into the buffer and load acc with result (post-wrap/clamp value) at the same edge.
REQ-022 Latency SHALL be 1: a pair accepted at edge N into an empty buffer appears with out_valid=1 from edge N onward (visible in cycle N+1).
REQ-023 Buffer SHALL be FIFO-ordered; out_port and out_ovf SHALL be stable while out_valid && !out_ready.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-025 Occupancy states: EMPTY (count=0, out_valid=0), PARTIAL, FULL (count=DEPTH, in_ready=0). Push-only increments count; pop-only decrements; otherwise count holds.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 in_port_1, in_port_2 and in_acc SHALL be ignored when no input transfer occurs; acc SHALL hold.

Reset
REQ-028 While reset=1 at an edge: count=0, pointers=0, acc=0, in_ready=0, out_valid=0, out_port=0, out_ovf=0.
REQ-029 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-030 Reset mid-operation SHALL discard all buffered results and any input presented in the same cycle.

Structure
REQ-031 Package add2_pkg SHALL hold the overflow-mode enumeration (WRAP, SAT) and the saturation helper function.
REQ-032 The buffer SHALL be a sub-module add2_pipe_fifo (WIDTH+1 data, DEPTH entries, push/pop/count).
REQ-033 Adder, overflow detection and accumulator SHALL live in add2_pipe.

Verification
REQ-034 WIDTH=32, out_ready=1: pairs (3,4) and (-5,2) on consecutive cycles -> out_port 7 then -3, ovf=0, one cycle after each transfer.
REQ-035 WIDTH=8, SATURATE=0: (100,100) -> out_port -56, ovf=1; SATURATE=1: same pair -> 127, ovf=1; (-100,-100) -> -128, ovf=1.
REQ-036 Accumulate: (1,2,in_acc=0), (10,0,in_acc=1), (0,0,in_acc=1) -> 3, 13, 13.
REQ-037 DEPTH=2, out_ready=0, in_valid held high: two transfers, then in_ready=0; raising out_ready pops in order, and in_ready returns one cycle after the first pop.
REQ-038 Reset pulsed while count=2 -> the next cycle shows out_valid=0 and acc=0; the next pair (1,1,in_acc=1) -> 2.
REQ-039 Random valid/ready toggling over 1000 pairs -> output sequence matches a reference model, with no loss, duplication or reordering.

Source files
------------

// File: rtl/add2_pkg.sv
// Shared types and helpers for the two-operand accumulating adder pipeline.
package add2_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } ovf_mode_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_HI   = 2'd1,
    DIR_LO   = 2'd2
  } sat_dir_e;

  // The top three bits of a two-bit-extended sum must agree when it fits in WIDTH.
  function automatic sat_dir_e sat_dir(input logic [2:0] top);
    if ((top == 3'b000) || (top == 3'b111)) begin
      return DIR_NONE;
    end
    return top[2] ? DIR_LO : DIR_HI;
  endfunction

endpackage

// File: rtl/add2_pipe_fifo.sv
// Result buffer: circular FIFO with registered head, occupancy flags and count.
module add2_pipe_fifo
  import add2_pkg::*;
#(
  parameter int DW    = 33,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic          o_not_full,
  output logic          o_not_empty,
  output logic [DW-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_not_full;
  logic             r_not_empty;
  logic [DW-1:0]    r_head;
  logic [DW-1:0]    w_head_nxt;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next occupancy and next head; a push lands at the head when it becomes the oldest entry.
  always_comb begin
    w_do_push   = i_push && r_not_full;
    w_do_pop    = i_pop && r_not_empty;
    w_rd_nxt    = w_do_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_wr_nxt    = w_do_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
    w_head_nxt = r_head;
    if (w_count_nxt != '0) begin
      w_head_nxt = (w_do_push && (r_wr_ptr == w_rd_nxt)) ? i_push_data : r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_not_full  <= 1'b0;
      r_not_empty <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
      end
      r_rd_ptr    <= w_rd_nxt;
      r_wr_ptr    <= w_wr_nxt;
      r_count     <= w_count_nxt;
      r_not_full  <= (w_count_nxt < CNT_W'(DEPTH));
      r_not_empty <= (w_count_nxt != '0);
      r_head      <= w_head_nxt;
    end
  end

  assign o_not_full  = r_not_full;
  assign o_not_empty = r_not_empty;
  assign o_head      = r_head;

endmodule

// File: rtl/add2_pipe.sv
// Signed two-operand adder with optional running accumulator, overflow flag,
// wrap/saturate modes and a small output FIFO.
module add2_pipe
  import add2_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_port_1,
  input  logic [WIDTH-1:0] in_port_2,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_port,
  output logic             out_ovf
);

  localparam int unsigned EXT_W = WIDTH + 2;
  localparam int unsigned DW    = WIDTH + 1;
  localparam ovf_mode_e   MODE  = (SATURATE != 0) ? SAT : WRAP;

  logic [WIDTH-1:0] r_acc;
  logic [EXT_W-1:0] w_a;
  logic [EXT_W-1:0] w_b;
  logic [EXT_W-1:0] w_c;
  logic [EXT_W-1:0] w_raw;
  sat_dir_e         w_dir;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_head;

  assign w_a   = {{2{in_port_1[WIDTH-1]}}, in_port_1};
  assign w_b   = {{2{in_port_2[WIDTH-1]}}, in_port_2};
  assign w_c   = in_acc ? {{2{r_acc[WIDTH-1]}}, r_acc} : '0;
  assign w_raw = w_a + w_b + w_c;
  assign w_dir = sat_dir(w_raw[EXT_W-1:WIDTH-1]);
  assign w_ovf = (w_dir != DIR_NONE);

  // Clamp only in saturate mode; wrap mode keeps the low WIDTH bits.
  always_comb begin
    w_result = w_raw[WIDTH-1:0];
    if (MODE == SAT) begin
      case (w_dir)
        DIR_HI:  w_result = {1'b0, {(WIDTH-1){1'b1}}};
        DIR_LO:  w_result = {1'b1, {(WIDTH-1){1'b0}}};
        default: w_result = w_raw[WIDTH-1:0];
      endcase
    end
  end

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Accumulator follows the stored (post-wrap/clamp) result of every accepted pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_push) begin
      r_acc <= w_result;
    end
  end

  add2_pipe_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_data({w_ovf, w_result}),
    .i_pop      (w_pop),
    .o_not_full (in_ready),
    .o_not_empty(out_valid),
    .o_head     (w_head)
  );

  assign out_port = w_head[WIDTH-1:0];
  assign out_ovf  = w_head[WIDTH];

endmodule
